// File: rtl/lu_dual_port_ram.sv
// lu_dual_port_ram: true dual-port Avalon-MM RAM with selectable read latency and a hardware clear sweep
module lu_dual_port_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic                s1_chipselect,
  input  logic                s1_write,
  input  logic                s1_read,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic                s2_chipselect,
  input  logic                s2_write,
  input  logic                s2_read,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);
  localparam int BE_W = DATA_W / 8;
  typedef enum logic {RUN, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic en, w;
  logic [1:0] cs, rd, wr, acc_rd, acc_wr, rvalid;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][BE_W-1:0] be;
  logic [1:0][DATA_W-1:0] wdata, rdata;
  assign en = clken & ~reset_req;
  assign clear_busy = state == CLEAR;
  assign w = clear_busy | ~en;
  assign s1_waitrequest = w;
  assign s2_waitrequest = w;
  assign cs = {s2_chipselect, s1_chipselect};
  assign rd = {s2_read, s1_read};
  assign wr = {s2_write, s1_write};
  assign addr = {s2_address, s1_address};
  assign be = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign acc_wr = cs & wr & {2{~w}};
  assign acc_rd = cs & rd & ~wr & {2{~w}};
  assign s1_readdata = rdata[0];
  assign s2_readdata = rdata[1];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdatavalid = rvalid[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt <= '0;
    end else if (state == CLEAR) begin
      if (en) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= RUN;
      end
    end else if (clken && clear_req) begin
      state <= CLEAR;
      cnt <= '0;
    end
  // s2 lanes are written first so that s1 overrides shared lanes on a collision
  always_ff @(posedge clk)
    if (en) begin
      if (state == CLEAR) mem[cnt] <= '0;
      for (int p = 1; p >= 0; p--)
        for (int i = 0; i < BE_W; i++)
          if (acc_wr[p] && be[p][i]) mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
    end
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] d1;
    logic v1;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        d1 <= '0;
        v1 <= 1'b0;
      end else if (en) begin
        v1 <= acc_rd[p];
        if (acc_rd[p]) d1 <= mem[addr[p]];
      end
    if (READ_LATENCY == 2) begin : g_l2
      logic [DATA_W-1:0] d2;
      logic v2;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else if (en) begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      assign rdata[p] = d2;
      assign rvalid[p] = v2;
    end else begin : g_l1
      assign rdata[p] = d1;
      assign rvalid[p] = v1;
    end
  end
endmodule

// File: tb/tb_lu_dual_port_ram.sv
// tb_lu_dual_port_ram: directed bench checking latency-1 and latency-2 instances against a word-level memory model
module tb_lu_dual_port_ram;
  logic clk = 0, reset = 1, clken = 1, reset_req = 0, clear_req = 0;
  logic [1:0] cs = 0, rd = 0, wr = 0;
  logic [1:0][3:0] be, ad;
  logic [1:0][31:0] wd;
  logic [3:0] o_v, o_w;
  logic [1:0] o_b;
  logic [3:0][31:0] o_d;
  logic [31:0] mem_m[16];
  logic busy_m = 1, start_m, ev_m;
  int cnt_m = 0, ecnt = 0;
  logic [31:0] qd[4][16];
  int qu[4][16];
  int hd[4] = '{0, 0, 0, 0}, tl[4] = '{0, 0, 0, 0};
  logic [31:0] last[4] = '{0, 0, 0, 0};
  int checks = 0, errors = 0, n1, n2, p0, p1;
  int pc[2] = '{0, 0};

  always #5 clk = ~clk;

  lu_dual_port_ram #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .clear_req(clear_req),
    .clear_busy(o_b[0]),
    .s1_chipselect(cs[0]), .s1_write(wr[0]), .s1_read(rd[0]), .s1_address(ad[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(o_d[0]),
    .s1_readdatavalid(o_v[0]), .s1_waitrequest(o_w[0]),
    .s2_chipselect(cs[1]), .s2_write(wr[1]), .s2_read(rd[1]), .s2_address(ad[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(o_d[1]),
    .s2_readdatavalid(o_v[1]), .s2_waitrequest(o_w[1]));

  lu_dual_port_ram #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .clear_req(clear_req),
    .clear_busy(o_b[1]),
    .s1_chipselect(cs[0]), .s1_write(wr[0]), .s1_read(rd[0]), .s1_address(ad[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(o_d[2]),
    .s1_readdatavalid(o_v[2]), .s1_waitrequest(o_w[2]),
    .s2_chipselect(cs[1]), .s2_write(wr[1]), .s2_read(rd[1]), .s2_address(ad[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(o_d[3]),
    .s2_readdatavalid(o_v[3]), .s2_waitrequest(o_w[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: response queue per (latency, port); an entry is due after a fixed count of enabled edges
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hd[i] = tl[i];
        last[i] = 0;
      end
      busy_m = 1;
      cnt_m = 0;
      ecnt = 0;
    end else begin
      start_m = clken && !busy_m && clear_req;
      if (clken && !reset_req) begin
        ecnt++;
        for (int i = 0; i < 4; i++)
          if (hd[i] != tl[i] && qu[i][hd[i] % 16] == ecnt - 1) begin
            last[i] = qd[i][hd[i] % 16];
            hd[i]++;
          end
        for (int p = 0; p < 2; p++)
          if (!busy_m && cs[p] && rd[p] && !wr[p])
            for (int l = 0; l < 2; l++) begin
              qd[l*2+p][tl[l*2+p] % 16] = mem_m[ad[p]];
              qu[l*2+p][tl[l*2+p] % 16] = ecnt + l;
              tl[l*2+p]++;
            end
        for (int p = 1; p >= 0; p--)
          if (!busy_m && cs[p] && wr[p])
            for (int b = 0; b < 4; b++)
              if (be[p][b]) mem_m[ad[p]][8*b +: 8] = wd[p][8*b +: 8];
        if (busy_m) begin
          mem_m[cnt_m] = 0;
          busy_m = cnt_m != 15;
          cnt_m = (cnt_m + 1) % 16;
        end
      end
      if (start_m) begin
        busy_m = 1;
        cnt_m = 0;
      end
    end
  end

  always @(negedge clk)
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        ev_m = hd[i] != tl[i] && qu[i][hd[i] % 16] == ecnt;
        chk("rvalid", 32'(o_v[i]), 32'(ev_m));
        chk("rdata", o_d[i], ev_m ? qd[i][hd[i] % 16] : last[i]);
        chk("waitrequest", 32'(o_w[i]), 32'(busy_m || !clken || reset_req));
      end
      for (int l = 0; l < 2; l++) chk("clear_busy", 32'(o_b[l]), 32'(busy_m));
    end

  always @(negedge clk)
    if (!reset && clken && !reset_req)
      for (int l = 0; l < 2; l++) pc[l] += int'(o_v[l*2+1]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 0;
    rd = 0;
    wr = 0;
    clear_req = 0;
  endtask

  task automatic busy_len(input string nm);
    n1 = 0;
    n2 = 0;
    repeat (20) begin
      @(negedge clk);
      n1 += int'(o_b[0]);
      n2 += int'(o_b[1]);
    end
    chk({nm, "_l1"}, n1, 16);
    chk({nm, "_l2"}, n2, 16);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      cs = 3;
      rd = 3;
      ad[0] = 4'(a);
      ad[1] = 4'(15 - a);
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  initial begin
    be = '0;
    ad = '0;
    wd = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = 0;
    repeat (3) tick();
    reset = 0;
    chk("rst_rvalid", 32'(o_v), 0);
    chk("rst_rdata_l1", o_d[0], 0);
    chk("rst_rdata_l2", o_d[3], 0);
    chk("rst_busy", 32'(o_b), 3);
    chk("rst_wait", 32'(o_w), 15);
    busy_len("busy_len");
    tick();
    read_all();
    cs = 1; wr = 1; ad[0] = 3; wd[0] = 32'hDEADBEEF; be[0] = 4'b0101;
    tick();
    wr = 0; rd = 1;
    tick();
    idle();
    chk("be_l1_valid", 32'(o_v[0]), 1);
    chk("be_l1_data", o_d[0], 32'h00AD00EF);
    chk("be_l2_early", 32'(o_v[2]), 0);
    tick();
    chk("be_l2_valid", 32'(o_v[2]), 1);
    chk("be_l2_data", o_d[2], 32'h00AD00EF);
    chk("be_l1_hold_v", 32'(o_v[0]), 0);
    chk("be_l1_hold_d", o_d[0], 32'h00AD00EF);
    cs = 3; wr = 3; ad[0] = 5; ad[1] = 5;
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; be[0] = 4'b0011; be[1] = 4'b1111;
    tick();
    wr = 0; cs = 1; rd = 1;
    tick();
    idle();
    chk("collision", o_d[0], 32'h22221111);
    chk("collision_model", mem_m[5], 32'h22221111);
    tick();
    cs = 1; wr = 1; ad[0] = 7; wd[0] = 32'hA5A5A5A5; be[0] = 4'hF;
    tick();
    cs = 3; wr = 1; rd = 2; ad[1] = 7; wd[0] = 32'h5A5A5A5A;
    tick();
    wr = 0; cs = 2; rd = 2;
    chk("rdw_old", o_d[1], 32'hA5A5A5A5);
    tick();
    idle();
    chk("rdw_new", o_d[1], 32'h5A5A5A5A);
    tick();
    cs = 2; rd = 2; wr = 2; ad[1] = 9; wd[1] = 32'h0BADF00D; be[1] = 4'hF;
    tick();
    idle();
    chk("rw_noread", 32'(o_v[1]), 0);
    chk("rw_write", mem_m[9], 32'h0BADF00D);
    for (int i = 0; i < 8; i++) begin
      cs = 1; wr = 1; ad[0] = 4'(8 + i); be[0] = 4'hF;
      wd[0] = 32'hC0000000 + 32'(i) * 32'h01010101;
      tick();
    end
    idle();
    p0 = pc[0];
    p1 = pc[1];
    for (int i = 0; i < 8; i++) begin
      cs = 2; rd = 2; ad[1] = 4'(8 + i);
      if (i == 4) begin
        clken = 0;
        repeat (3) tick();
        clken = 1;
      end
      if (i == 6) begin
        reset_req = 1;
        tick();
        reset_req = 0;
      end
      tick();
    end
    idle();
    repeat (4) tick();
    chk("burst_count_l1", pc[0] - p0, 8);
    chk("burst_count_l2", pc[1] - p1, 8);
    chk("burst_last_l1", o_d[1], 32'hC7070707);
    chk("burst_last_l2", o_d[3], 32'hC7070707);
    clear_req = 1;
    tick();
    clear_req = 0;
    chk("clr_busy", 32'(o_b), 3);
    repeat (5) tick();
    #2 reset = 1;
    tick();
    reset = 0;
    busy_len("busy_restart");
    tick();
    read_all();
    cs = 1; rd = 1; ad[0] = 7;
    tick();
    idle();
    chk("post_clear", o_d[0], 0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lu_dual_port_ram.md
# lu_dual_port_ram

Parametrised true-dual-port on-chip RAM for the LU linear-equation solver system. Port s1 serves the Nios/host; port s2 serves the solver datapath, which streams matrix rows. Both are Avalon-MM slaves with selectable read latency, `readdatavalid`, byte enables and `waitrequest`. Adds a hardware clear engine that zeroes the array after reset or on request, so no init file is needed between solves.

## Interface
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `ADDR_W`, default 13: word address width; depth = 2^ADDR_W.
- `READ_LATENCY`, default 1: 1 = unregistered RAM output; 2 = extra output register.
- `CLEAR_ON_RESET`, default 1: 1 = run the clear sweep after reset deassertion.
- `clk`  in  1  single clock for both ports.
- `reset`  in  1  asynchronous, active-high.
- `clken`  in  1  global clock enable; 0 freezes the array, the pipelines and the clear FSM.
- `reset_req`  in  1  1 suppresses all array accesses (writes and reads) for that cycle.
- `clear_req`  in  1  one-cycle pulse; starts a clear sweep.
- `clear_busy`  out  1  1 while a sweep is running.
- `s1_chipselect`, `s1_write`, `s1_read`  in  1 each  port-1 controls.
- `s1_address`  in  ADDR_W  port-1 word address.
- `s1_byteenable`  in  DATA_W/8  port-1 lane enables.
- `s1_writedata`  in  DATA_W  port-1 write data.
- `s1_readdata`  out  DATA_W  port-1 read data.
- `s1_readdatavalid`, `s1_waitrequest`  out  1 each  port-1 status.
- `s2_*`: identical set for port 2.

## Operation
- Two-state FSM: CLEAR, RUN.
- Reset entry:
  - With CLEAR_ON_RESET=1: reset enters CLEAR with the clear counter at 0.
  - With CLEAR_ON_RESET=0: reset enters RUN.
- CLEAR:
  - Each enabled cycle (`clken`=1, `reset_req`=0) writes 0 to `mem[cnt]` with all lanes, then increments `cnt`.
  - At `cnt` = 2^ADDR_W-1 the FSM goes to RUN after that write.
  - Sweep length is 2^ADDR_W enabled cycles.
- RUN: a `clear_req` sampled with `clken`=1 enters CLEAR with `cnt`=0. A `clear_req` during CLEAR is ignored; the sweep does not restart.
- `waitrequest` on both ports = (state==CLEAR) | ~clken | reset_req. An access is accepted only when `chipselect` & (`read`|`write`) & ~`waitrequest`.
- Write: only lanes with `byteenable[i]`=1 update `mem[addr][8i+7:8i]`.
- `read` and `write` both high on one port in one cycle: the write is performed and no read is issued.
- Read-during-write, same port: returns old data.
- Read-during-write, mixed ports at the same address: the reader returns old data.
- Write collision (s1 and s2 write the same address in the same cycle):
  - s1 lanes win where both enable a lane.
  - Lanes enabled only by s2 take s2's data.
- Read responses are in order, one per accepted read. `readdata` holds its last value when `readdatavalid`=0.
- `freeze` from the previous generation is dropped; its function is covered by `clken`.

## Timing
- Reset values:
  - `readdata`=0 and `readdatavalid`=0 on both ports.
  - `clear_busy`=CLEAR_ON_RESET.
  - `waitrequest`=CLEAR_ON_RESET; `reset_req`/`clken` can still force it high.
- Read latency is measured from the accepting edge.
  - READ_LATENCY=1: `readdatavalid` and data valid in the cycle after acceptance.
  - READ_LATENCY=2: valid two cycles after acceptance.
- Throughput is one access per port per cycle, with back-to-back reads fully pipelined.
- `clken`=0 stalls every pipeline stage. A pending `readdatavalid` is held and re-presented after `clken` returns, never duplicated.
- `reset_req`=1 stalls the pipelines exactly like `clken`=0. No access is accepted.
- `clear_busy` rises in the cycle after the accepting `clear_req` edge and falls in the cycle after the last clear write. `waitrequest` tracks it.
- Reads in flight when CLEAR starts still complete with pre-clear data.
- Asynchronous reset mid-sweep:
  - Aborts the sweep and empties the pipelines.
  - Restarts from 0 on deassertion if CLEAR_ON_RESET=1.
  - If CLEAR_ON_RESET=0, array contents are undefined.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=4:
  - `waitrequest` stays 1 for 16 cycles after deassertion, then falls.
  - Reads of all 16 words return 0x00000000.
- Port s1 writes 0xDEADBEEF to addr 3 with `byteenable`=4'b0101, then reads addr 3 → 0x00AD00EF.
  - With READ_LATENCY=1: `readdatavalid` one cycle after acceptance.
  - With READ_LATENCY=2: two cycles after.
- Same-cycle writes to addr 5:
  - s1 writes 0x11111111 with `byteenable`=4'b0011; s2 writes 0x22222222 with 4'b1111.
  - A subsequent read returns 0x22221111.
- Mixed-port read-during-write:
  - Setup: addr 7 holds 0xA5A5A5A5.
  - s2 reads addr 7 in the same cycle s1 writes 0x5A5A5A5A there.
  - s2 gets 0xA5A5A5A5; the next s2 read gets 0x5A5A5A5A.
- Clock-enable stall:
  - 8 back-to-back s2 reads; `clken` drops for 3 cycles mid-burst.
  - Exactly 8 `readdatavalid` pulses, correct data, in order.
- `clear_req` pulse in RUN, then async `reset` pulse mid-sweep:
  - The sweep restarts from address 0.
  - `clear_busy` is high for a full 2^ADDR_W cycles after reset release.
  - All words read back 0.
